// File: rtl/addsub_pkg.sv
// addsub_pkg: shared definitions for the bit-serial adder/subtractor.
//   MODE_ADD / MODE_SUB : operation select encoding
//   state_e             : controller state encoding (ST_IDLE, ST_RUN)
//   clog2()             : index-register width helper
package addsub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Smallest n with 2**n >= value; used for elaboration-time sizing only.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned n;
        n = 0;
        while ((64'd1 << n) < 64'(value)) begin
            n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/addsub_cell.sv
// addsub_cell: combinational one-bit full adder / full subtractor.
//   a, b  in  operand bits
//   c     in  carry-in (add) or borrow-in (subtract)
//   mode  in  MODE_ADD or MODE_SUB
//   s     out sum / difference bit
//   co    out carry-out (add) or borrow-out (subtract)
module addsub_cell
    import addsub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic mode,
    output logic s,
    output logic co
);

    logic w_p;

    // Sum and difference bits are the same xor; only the carry/borrow differs.
    assign w_p = a ^ b;
    assign s   = w_p ^ c;

    always_comb begin
        if (mode == MODE_SUB) begin
            co = (~a & b) | (~w_p & c);
        end else begin
            co = (a & b) | (w_p & c);
        end
    end

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial two's-complement adder/subtractor, one bit per clock.
//   Parameter WIDTH (2..64) sets operand/result width.
//   clk, rst_n      clock, asynchronous active-low reset
//   start           request pulse, sampled only while busy=0
//   mode            0 = a+b+c_in, 1 = a-b-c_in (c_in is borrow-in)
//   a, b, c_in      operands, sampled with start
//   busy            operation in progress
//   done            one-cycle completion pulse
//   result, c_out   sum/difference and carry/borrow of last completed operation
//   ovf             signed overflow of last completed operation
// Optional feature: define SERIAL_ADDSUB_OVF_EN to build the overflow logic;
// without it ovf is tied to 0.
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             ovf
);

    localparam int unsigned IDX_W = clog2(WIDTH);

    state_e             r_state;
    state_e             w_state_d;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    // Holds the WIDTH-1 most recent result bits; the current bit completes the word.
    logic [WIDTH-2:0]   r_work;
    logic [WIDTH-1:0]   w_work_d;
    logic               r_carry;
    logic               r_mode;
    logic [IDX_W-1:0]   r_idx;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;
    logic               r_c_out;

    logic               w_load;
    logic               w_step;
    logic               w_finish;
    logic               w_last;
    logic               w_s;
    logic               w_co;

    addsub_cell u_cell (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .c    (r_carry),
        .mode (r_mode),
        .s    (w_s),
        .co   (w_co)
    );

    assign w_last   = (r_idx == IDX_W'(WIDTH - 1));
    assign w_work_d = {w_s, r_work};

    // Next-state and step control.
    always_comb begin
        w_state_d = r_state;
        w_load    = 1'b0;
        w_step    = 1'b0;
        w_finish  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load    = 1'b1;
                    w_state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_finish  = 1'b1;
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Operand shifters, carry flop and bit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_work  <= '0;
            r_carry <= 1'b0;
            r_mode  <= MODE_ADD;
            r_idx   <= '0;
        end else if (w_load) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= c_in;
            r_mode  <= mode;
            r_idx   <= '0;
        end else if (w_step) begin
            r_a_sh  <= r_a_sh >> 1;
            r_b_sh  <= r_b_sh >> 1;
            r_work  <= w_work_d[WIDTH-1:1];
            r_carry <= w_co;
            r_idx   <= r_idx + IDX_W'(1);
        end
    end

    // Completion registers: change only on the edge that registers the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done   <= 1'b0;
            r_result <= '0;
            r_c_out  <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_finish) begin
                r_result <= w_work_d;
                r_c_out  <= w_co;
            end
        end
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    logic r_ovf;

    // At the MSB step r_carry is the carry/borrow into the MSB, w_co the one out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_finish) begin
            r_ovf <= r_carry ^ w_co;
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    assign busy   = (r_state == ST_RUN);
    assign done   = r_done;
    assign result = r_result;
    assign c_out  = r_c_out;

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: self-checking bench for serial_addsub.
//   u_dut8 (WIDTH=8) runs directed vectors, checked every cycle against an
//   arithmetic reference model plus literal expectations.
//   u_dut4 (WIDTH=4) runs an exhaustive sweep against the same reference.
module tb_serial_addsub;

    typedef struct {
        logic [63:0] res;
        logic        cout;
        logic        ovf;
    } res_t;

    logic       clk;
    logic       rst_n;

    logic       start;
    logic       mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       c_in;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       c_out;
    logic       ovf;

    logic       s4_start;
    logic       s4_mode;
    logic [3:0] s4_a;
    logic [3:0] s4_b;
    logic       s4_c_in;
    logic       s4_busy;
    logic       s4_done;
    logic [3:0] s4_result;
    logic       s4_c_out;
    logic       s4_ovf;

    int total;
    int bad;

    serial_addsub #(.WIDTH(8)) u_dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .mode   (mode),
        .a      (a),
        .b      (b),
        .c_in   (c_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .c_out  (c_out),
        .ovf    (ovf)
    );

    serial_addsub #(.WIDTH(4)) u_dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (s4_start),
        .mode   (s4_mode),
        .a      (s4_a),
        .b      (s4_b),
        .c_in   (s4_c_in),
        .busy   (s4_busy),
        .done   (s4_done),
        .result (s4_result),
        .c_out  (s4_c_out),
        .ovf    (s4_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic: true unsigned and signed values, then wrap.
    function automatic res_t calc(input int w, input logic md, input logic [63:0] x,
                                  input logic [63:0] y, input logic ci);
        res_t   r;
        longint one_w;
        longint half;
        longint ux;
        longint uy;
        longint sx;
        longint sy;
        longint full_u;
        longint full_s;
        one_w = longint'(1) << w;
        half  = one_w >> 1;
        ux    = longint'(x) & (one_w - 1);
        uy    = longint'(y) & (one_w - 1);
        sx    = (ux >= half) ? ux - one_w : ux;
        sy    = (uy >= half) ? uy - one_w : uy;
        if (md) begin
            full_u = ux - uy - longint'(ci);
            full_s = sx - sy - longint'(ci);
            r.cout = (full_u < 0);
        end else begin
            full_u = ux + uy + longint'(ci);
            full_s = sx + sy + longint'(ci);
            r.cout = (full_u >= one_w);
        end
        r.res = 64'(full_u & (one_w - 1));
`ifdef SERIAL_ADDSUB_OVF_EN
        r.ovf = (full_s < -half) || (full_s > half - 1);
`else
        r.ovf = 1'b0;
`endif
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Protocol-level model of the 8-bit instance: countdown of remaining cycles.
    int         m_cnt;
    logic       m_done;
    logic [7:0] m_res;
    logic       m_cout;
    logic       m_ovf;
    logic       m_md;
    logic [7:0] m_a;
    logic [7:0] m_b;
    logic       m_ci;
    res_t       m_r;

    always_comb m_r = calc(8, m_md, 64'(m_a), 64'(m_b), m_ci);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_res  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
            m_md   <= 1'b0;
            m_a    <= '0;
            m_b    <= '0;
            m_ci   <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt == 0) begin
                if (start) begin
                    m_cnt <= 8;
                    m_md  <= mode;
                    m_a   <= a;
                    m_b   <= b;
                    m_ci  <= c_in;
                end
            end else begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_done <= 1'b1;
                    m_res  <= m_r.res[7:0];
                    m_cout <= m_r.cout;
                    m_ovf  <= m_r.ovf;
                end
            end
        end
    end

    // Cycle-by-cycle compare of the 8-bit instance against the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            check("cyc_busy", 64'(busy), 64'(m_cnt != 0));
            check("cyc_done", 64'(done), 64'(m_done));
            check("cyc_result", 64'(result), 64'(m_res));
            check("cyc_c_out", 64'(c_out), 64'(m_cout));
            check("cyc_ovf", 64'(ovf), 64'(m_ovf));
        end
    end

    // Waits for done after the accepting edge; returns edges counted.
    task automatic wait_done8(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 30);
        if (!done) begin
            bad++;
            total++;
            $display("FAIL done8_timeout actual=%0d required=8", n);
        end
    endtask

    task automatic op8(input string nm, input logic md, input logic [7:0] x,
                       input logic [7:0] y, input logic ci, input logic [7:0] er,
                       input logic ec, input logic eo_en);
        int n;
        @(negedge clk);
        start = 1'b1;
        mode  = md;
        a     = x;
        b     = y;
        c_in  = ci;
        @(negedge clk);
        start = 1'b0;
        wait_done8(n);
        check({nm, "_lat"}, 64'(n), 64'd8);
        check({nm, "_res"}, 64'(result), 64'(er));
        check({nm, "_cout"}, 64'(c_out), 64'(ec));
`ifdef SERIAL_ADDSUB_OVF_EN
        check({nm, "_ovf"}, 64'(ovf), 64'(eo_en));
`else
        check({nm, "_ovf"}, 64'(ovf), 64'(1'b0 & eo_en));
`endif
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_busy"}, 64'(busy), 64'd0);
        check({nm, "_done"}, 64'(done), 64'd0);
        check({nm, "_result"}, 64'(result), 64'd0);
        check({nm, "_c_out"}, 64'(c_out), 64'd0);
        check({nm, "_ovf"}, 64'(ovf), 64'd0);
    endtask

    initial begin
        int   n;
        res_t r4;
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        mode     = 1'b0;
        a        = '0;
        b        = '0;
        c_in     = 1'b0;
        s4_start = 1'b0;
        s4_mode  = 1'b0;
        s4_a     = '0;
        s4_b     = '0;
        s4_c_in  = 1'b0;

        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // Directed vectors; consecutive calls start during the done cycle.
        op8("add_3c_15", 1'b0, 8'h3C, 8'h15, 1'b0, 8'h51, 1'b0, 1'b0);
        op8("add_ff_01", 1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0);
        op8("add_7f_01", 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        op8("sub_10_20", 1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0);
        op8("sub_80_01", 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        op8("sub_05_05", 1'b1, 8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 1'b0);

        // start during a running add is ignored; previous result held meanwhile.
        @(negedge clk);
        start = 1'b1;
        mode  = 1'b0;
        a     = 8'h3C;
        b     = 8'h15;
        c_in  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("ign_busy", 64'(busy), 64'd1);
        check("ign_hold", 64'(result), 64'hFF);
        start = 1'b1;
        mode  = 1'b1;
        a     = 8'hAA;
        b     = 8'h11;
        c_in  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done8(n);
        check("ign_lat", 64'(n), 64'd6);
        check("ign_res", 64'(result), 64'h51);
        check("ign_cout", 64'(c_out), 64'd0);
        @(negedge clk);
        check("ign_no_restart", 64'(busy), 64'd0);

        // Reset during cycle 4 of an operation aborts it.
        @(negedge clk);
        start = 1'b1;
        mode  = 1'b0;
        a     = 8'hF0;
        b     = 8'h20;
        c_in  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_no_done_res", 64'(result), 64'd0);
        op8("after_rst", 1'b0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

        // Exhaustive 4-bit sweep.
        for (int md = 0; md < 2; md++) begin
            for (int ci = 0; ci < 2; ci++) begin
                for (int x = 0; x < 16; x++) begin
                    for (int y = 0; y < 16; y++) begin
                        @(negedge clk);
                        s4_start = 1'b1;
                        s4_mode  = md[0];
                        s4_c_in  = ci[0];
                        s4_a     = x[3:0];
                        s4_b     = y[3:0];
                        @(negedge clk);
                        s4_start = 1'b0;
                        n = 0;
                        do begin
                            @(posedge clk);
                            #1;
                            n++;
                        end while (!s4_done && n < 20);
                        r4 = calc(4, md[0], 64'(x), 64'(y), ci[0]);
                        check("w4_lat", 64'(n), 64'd4);
                        check("w4_res", 64'(s4_result), r4.res);
                        check("w4_cout", 64'(s4_c_out), 64'(r4.cout));
                        check("w4_ovf", 64'(s4_ovf), 64'(r4.ovf));
                    end
                end
            end
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
